// File: rtl/id_ex_pipe_reg_if.sv
// ============================================================================
// Module   : id_ex_pipe_reg_if
// Brief    : ID-side inputs and EX-side registered outputs of the ID/EX register.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface id_ex_pipe_reg_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm32;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src_b;
  logic [1:0]  id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm32;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_shamt;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_alu_src_b;
  logic [1:0]  ex_reg_dst;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;

  modport master (
    output id_valid, id_pc, id_rs_data, id_rt_data, id_imm32, id_rs, id_rt, id_rd,
           id_shamt, id_uses_rs, id_uses_rt, id_alu_ctrl, id_alu_src_b, id_reg_dst,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt, ex_rd,
           ex_shamt, ex_alu_ctrl, ex_alu_src_b, ex_reg_dst, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg
  );

  modport slave (
    input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm32, id_rs, id_rt, id_rd,
           id_shamt, id_uses_rs, id_uses_rt, id_alu_ctrl, id_alu_src_b, id_reg_dst,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt, ex_rd,
           ex_shamt, ex_alu_ctrl, ex_alu_src_b, ex_reg_dst, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// Module   : id_ex_pipe_reg
// Brief    : ID/EX pipeline register with load-use bubble insertion and counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe_reg #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             stall,
  input  wire logic             flush,
  id_ex_pipe_reg_if.slave       bus,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_update;
  logic             w_load;
  logic             w_ctrl_ok;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Writes to $0 never create a real dependency, so they are excluded.
  assign w_rs_hit = bus.id_uses_rs & (bus.ex_rt == bus.id_rs);
  assign w_rt_hit = bus.id_uses_rt & (bus.ex_rt == bus.id_rt);
  assign load_use_stall = bus.ex_valid & bus.ex_mem_read & bus.id_valid &
                          (bus.ex_rt != 5'd0) & (w_rs_hit | w_rt_hit);

  // Flush beats stall; a bubble is simply an update with every field zeroed.
  assign w_update  = flush | ~stall;
  assign w_load    = ~flush & ~load_use_stall;
  assign w_ctrl_ok = w_load & bus.id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_pc         <= '0;
      bus.ex_rs_data    <= '0;
      bus.ex_rt_data    <= '0;
      bus.ex_imm32      <= '0;
      bus.ex_rs         <= '0;
      bus.ex_rt         <= '0;
      bus.ex_rd         <= '0;
      bus.ex_shamt      <= '0;
      bus.ex_alu_ctrl   <= '0;
      bus.ex_alu_src_b  <= 1'b0;
      bus.ex_reg_dst    <= '0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
    end else if (w_update) begin
      bus.ex_valid      <= w_load & bus.id_valid;
      bus.ex_pc         <= w_load ? bus.id_pc      : '0;
      bus.ex_rs_data    <= w_load ? bus.id_rs_data : '0;
      bus.ex_rt_data    <= w_load ? bus.id_rt_data : '0;
      bus.ex_imm32      <= w_load ? bus.id_imm32   : '0;
      bus.ex_rs         <= w_load ? bus.id_rs      : '0;
      bus.ex_rt         <= w_load ? bus.id_rt      : '0;
      bus.ex_rd         <= w_load ? bus.id_rd      : '0;
      bus.ex_shamt      <= w_load ? bus.id_shamt   : '0;
      bus.ex_alu_ctrl   <= w_load ? bus.id_alu_ctrl : '0;
      bus.ex_alu_src_b  <= w_load & bus.id_alu_src_b;
      bus.ex_reg_dst    <= w_load ? bus.id_reg_dst : '0;
      bus.ex_reg_write  <= w_ctrl_ok & bus.id_reg_write;
      bus.ex_mem_read   <= w_ctrl_ok & bus.id_mem_read;
      bus.ex_mem_write  <= w_ctrl_ok & bus.id_mem_write;
      bus.ex_mem_to_reg <= w_load & bus.id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (~flush & ~stall & load_use_stall & (r_bubble_cnt != c_cnt_max)) begin
      r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// ============================================================================
// Module   : tb_id_ex_pipe_reg
// Brief    : Directed scoreboard bench for the ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_pipe_reg;

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic        uses_rs, uses_rt;
    logic [3:0]  alu_ctrl;
    logic        alu_src_b;
    logic [1:0]  reg_dst;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
  } vec_t;

  typedef struct {
    logic       lu;
    vec_t       ld;
    logic [3:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       flush;
  logic       load_use_stall;
  logic [3:0] bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];

  id_ex_pipe_reg_if bus();

  id_ex_pipe_reg #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  function automatic vec_t zero_vec();
    vec_t v;
    v.stall = 0; v.flush = 0; v.valid = 0;
    v.pc = 0; v.rs_data = 0; v.rt_data = 0; v.imm = 0;
    v.rs = 0; v.rt = 0; v.rd = 0; v.shamt = 0;
    v.uses_rs = 0; v.uses_rt = 0; v.alu_ctrl = 0; v.alu_src_b = 0; v.reg_dst = 0;
    v.reg_write = 0; v.mem_read = 0; v.mem_write = 0; v.mem_to_reg = 0;
    return v;
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic us, input logic ut,
                              input logic rw, input logic mr, input logic mw);
    vec_t v = zero_vec();
    v.valid = 1; v.pc = pc; v.imm = imm; v.rs = rs; v.rt = rt;
    v.uses_rs = us; v.uses_rt = ut;
    v.reg_write = rw; v.mem_read = mr; v.mem_write = mw; v.mem_to_reg = mr;
    v.rs_data = pc ^ 32'h1111_0000;
    v.rt_data = imm ^ 32'h2222_0000;
    v.rd = rt + 5'd1;
    v.shamt = pc[6:2];
    v.alu_ctrl = pc[5:2];
    v.alu_src_b = mr | mw;
    v.reg_dst = {1'b0, ~mr};
    return v;
  endfunction

  function automatic exp_t ex(input logic lu, input vec_t ld, input int cnt);
    exp_t e;
    e.lu = lu; e.ld = ld; e.cnt = 4'(cnt);
    return e;
  endfunction

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush;
    bus.id_valid = v.valid; bus.id_pc = v.pc; bus.id_rs_data = v.rs_data;
    bus.id_rt_data = v.rt_data; bus.id_imm32 = v.imm; bus.id_rs = v.rs;
    bus.id_rt = v.rt; bus.id_rd = v.rd; bus.id_shamt = v.shamt;
    bus.id_uses_rs = v.uses_rs; bus.id_uses_rt = v.uses_rt;
    bus.id_alu_ctrl = v.alu_ctrl; bus.id_alu_src_b = v.alu_src_b;
    bus.id_reg_dst = v.reg_dst; bus.id_reg_write = v.reg_write;
    bus.id_mem_read = v.mem_read; bus.id_mem_write = v.mem_write;
    bus.id_mem_to_reg = v.mem_to_reg;
  endtask

  // Called just after a rising edge; the expectation covers this cycle's
  // load_use_stall and the EX state after the next edge.
  task automatic issue(input vec_t v, input exp_t e);
    drive(v);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: at each falling edge check EX state of the pending entry,
  // then pop the next entry and check its combinational hazard flag.
  initial begin
    exp_t pend;
    bit   have_pend = 0;
    forever begin
      @(negedge clk);
      if (have_pend) begin
        chk("ex_valid", 32'(bus.ex_valid), 32'(pend.ld.valid));
        chk("ex_pc", bus.ex_pc, pend.ld.pc);
        chk("ex_rs_data", bus.ex_rs_data, pend.ld.rs_data);
        chk("ex_rt_data", bus.ex_rt_data, pend.ld.rt_data);
        chk("ex_imm32", bus.ex_imm32, pend.ld.imm);
        chk("ex_rs", 32'(bus.ex_rs), 32'(pend.ld.rs));
        chk("ex_rt", 32'(bus.ex_rt), 32'(pend.ld.rt));
        chk("ex_rd", 32'(bus.ex_rd), 32'(pend.ld.rd));
        chk("ex_shamt", 32'(bus.ex_shamt), 32'(pend.ld.shamt));
        chk("ex_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'(pend.ld.alu_ctrl));
        chk("ex_alu_src_b", 32'(bus.ex_alu_src_b), 32'(pend.ld.alu_src_b));
        chk("ex_reg_dst", 32'(bus.ex_reg_dst), 32'(pend.ld.reg_dst));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(pend.ld.reg_write));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(pend.ld.mem_read));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(pend.ld.mem_write));
        chk("ex_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(pend.ld.mem_to_reg));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(pend.cnt));
        have_pend = 0;
      end
      if (q.size() > 0) begin
        pend = q.pop_front();
        chk("load_use_stall", 32'(load_use_stall), 32'(pend.lu));
        have_pend = 1;
      end
    end
  end

  initial begin
    vec_t z, v0, v_add, v_lw, v_dep, v_lw0, v_dep0, v_nors, v_rtdep, v_st;
    vec_t v_s, v_depw, v_inv, e_inv;
    int c;

    z = zero_vec();
    rst = 1'b1;
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(bus.ex_valid), 0);
    chk("rst_ex_imm32", bus.ex_imm32, 0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 0);
    chk("rst_load_use", 32'(load_use_stall), 0);
    rst = 1'b0;

    v0 = z;
    v0.valid = 1; v0.imm = 32'hFFFF_8000; v0.alu_src_b = 1; v0.reg_write = 1;
    drive(v0);
    @(posedge clk);
    #1;
    chk("first_ex_imm32", bus.ex_imm32, 32'hFFFF_8000);
    chk("first_ex_reg_write", 32'(bus.ex_reg_write), 1);
    chk("first_ex_valid", 32'(bus.ex_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ex_valid", 32'(bus.ex_valid), 0);
    chk("async_rst_ex_imm32", bus.ex_imm32, 0);
    chk("async_rst_ex_reg_write", 32'(bus.ex_reg_write), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    v_add   = mk(32'h0040_0004, 32'h0000_0010, 5'd1, 5'd2, 1, 1, 1, 0, 0);
    v_lw    = mk(32'h0040_0008, 32'h0000_0004, 5'd1, 5'd5, 1, 0, 1, 1, 0);
    v_dep   = mk(32'h0040_000C, 32'h0000_0000, 5'd5, 5'd6, 1, 1, 1, 0, 0);
    v_lw0   = mk(32'h0040_0020, 32'h0000_0008, 5'd1, 5'd0, 1, 0, 1, 1, 0);
    v_dep0  = mk(32'h0040_0024, 32'h0000_0000, 5'd0, 5'd6, 1, 1, 1, 0, 0);
    v_nors  = mk(32'h0040_0028, 32'h0000_0003, 5'd5, 5'd6, 0, 0, 1, 0, 0);
    v_rtdep = mk(32'h0040_002C, 32'h0000_0000, 5'd7, 5'd5, 1, 1, 1, 0, 0);
    v_st    = mk(32'h0040_0010, 32'h0000_0020, 5'd8, 5'd9, 1, 0, 1, 0, 0);

    // Normal flow, then a true load-use on rs: one bubble, then the load.
    issue(v_add,  ex(0, v_add, 0));
    issue(v_lw,   ex(0, v_lw,  0));
    issue(v_dep,  ex(1, z,     1));
    issue(v_dep,  ex(0, v_dep, 1));
    // No hazard when the load targets $0 or when rs/rt are unused.
    issue(v_lw0,  ex(0, v_lw0,  1));
    issue(v_dep0, ex(0, v_dep0, 1));
    issue(v_lw,   ex(0, v_lw,   1));
    issue(v_nors, ex(0, v_nors, 1));
    // Hazard through the rt port.
    issue(v_lw,    ex(0, v_lw,    1));
    issue(v_rtdep, ex(1, z,       2));
    issue(v_rtdep, ex(0, v_rtdep, 2));
    // Stall holds EX for three cycles while ID changes.
    issue(v_st, ex(0, v_st, 2));
    v_s = v_add; v_s.stall = 1; issue(v_s, ex(0, v_st, 2));
    v_s = v_lw;  v_s.stall = 1; issue(v_s, ex(0, v_st, 2));
    v_s = v_dep; v_s.stall = 1; issue(v_s, ex(0, v_st, 2));
    issue(v_add, ex(0, v_add, 2));
    // Stall over a live hazard holds the counter; flush then wins over both.
    issue(v_lw, ex(0, v_lw, 2));
    v_s = v_dep; v_s.stall = 1; issue(v_s, ex(1, v_lw, 2));
    v_depw = v_dep; v_depw.mem_write = 1; v_depw.stall = 1; v_depw.flush = 1;
    issue(v_depw, ex(1, z, 2));
    // Invalid instruction: fields captured, side-effecting controls suppressed.
    v_inv = v_add; v_inv.valid = 0; v_inv.mem_read = 1; v_inv.mem_write = 1; v_inv.mem_to_reg = 1;
    e_inv = v_inv; e_inv.reg_write = 0; e_inv.mem_read = 0; e_inv.mem_write = 0;
    issue(v_inv, ex(0, e_inv, 2));
    // 17 more bubbles: the 4-bit counter saturates at 15.
    c = 2;
    for (int k = 0; k < 17; k++) begin
      issue(v_lw, ex(0, v_lw, c));
      c = (c == 15) ? 15 : c + 1;
      issue(v_dep, ex(1, z, c));
      issue(v_dep, ex(0, v_dep, c));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage CPU. Sits directly downstream of the immediate extender and the register file read ports.
- Latches the 32-bit extended immediate, the operands, register specifiers and decoded control for the EX stage.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles. Honours a global stall and a branch flush.
- Counts inserted load-use bubbles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating load-use bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  global freeze from later stages; hold all state.
- flush  in  1  branch/jump resolved in EX; discard the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC+4 of the ID instruction.
- id_rs_data  in  32  register file read port A.
- id_rt_data  in  32  register file read port B.
- id_imm32  in  32  extended immediate from the extender.
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields.
- id_uses_rs, id_uses_rt  in  1 each  the instruction reads rs/rt.
- id_alu_ctrl  in  4  ALU operation.
- id_alu_src_b  in  1  selects immediate (1) or rt_data (0).
- id_reg_dst  in  2  write-register select.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control.
- ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt, ex_rd, ex_shamt, ex_alu_ctrl, ex_alu_src_b, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  matching widths  registered copies.
- load_use_stall  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (async, rst=1): every registered output is 0 and bubble_cnt is 0. Effect is immediate and overrides everything else. A reset mid-operation discards the in-flight instruction; first load occurs on the first rising edge after rst falls.
- load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & ((id_uses_rs & ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- load_use_stall depends only on current outputs and inputs. It is not gated by stall or flush; upstream logic qualifies it.
- Per rising edge, first match wins:
  1. flush=1: bubble.
  2. stall=1: hold all registers and the counter.
  3. load_use_stall=1: bubble, and bubble_cnt increments.
  4. Otherwise: load all id_* fields into ex_*, including ex_valid <= id_valid.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_mem_to_reg go to 0. All data, specifier and ALU fields also go to 0, so a bubble is deterministic.
- id_valid=0 on a normal load: fields are captured as presented, but ex_reg_write, ex_mem_read and ex_mem_write are forced to 0.
- Latency: one cycle from ID inputs to ex_* outputs. There is no combinational path from id_* to ex_*.
- bubble_cnt increments only on case 3 edges. It saturates at 2^CNT_W-1 and never wraps.
- flush and load_use_stall together: the result is a flush bubble and the counter does not increment.
- Only one bubble is inserted per load-use pair. After the bubble, ex_mem_read=0, so load_use_stall drops and the dependent instruction loads on the following edge.
- A hazard on $0 (ex_rt==0) never stalls.

Test Plan:
- Reset then normal load: rst pulse mid-cycle; all outputs read 0 asynchronously. Then apply id_valid=1, id_imm32=0xFFFF8000, id_alu_src_b=1, id_reg_write=1. After one edge, ex_imm32=0xFFFF8000, ex_reg_write=1, ex_valid=1.
- Load-use: EX holds lw with ex_rt=5 and ex_mem_read=1; ID has id_rs=5, id_uses_rs=1. Expect load_use_stall=1 the same cycle. Next edge gives a bubble (ex_valid=0, all controls 0) and bubble_cnt=1. The following edge loads the dependent instruction and load_use_stall=0.
- No false hazard: same as the load-use case but with ex_rt=0, or with id_uses_rs=0. Expect load_use_stall=0 and a normal load.
- Stall hold: ex_* loaded with ex_pc=0x00400010; assert stall for 3 cycles while id_* changes. ex_* and bubble_cnt stay unchanged; a load occurs on the first edge after stall deasserts.
- Flush priority: flush=1 together with stall=1 and a load-use condition. Next edge gives a bubble, bubble_cnt is unchanged, and ex_mem_write=0.
- Counter saturation: with CNT_W=4, force 17 load-use bubbles. bubble_cnt reaches 15 and stays at 15.
